// File: rtl/usb_bulk_in_ep.sv
// Bulk IN endpoint: buffers one packet from a show-ahead queue and serves it to the usb core
// with NAK, DATA0/DATA1 toggling and retransmission. Optional zero-length packets: USB_BULK_IN_ZLP_EN.
module usb_bulk_in_ep #(
    parameter logic [3:0] EP_NUM  = 4'h1,
    parameter int         MAX_PKT = 64,
    parameter int         CNT_W   = 7
) (
    input  logic             clk48mhz,
    input  logic             rst,
    input  logic             usb_rst,
    input  logic [3:0]       endpoint,
    input  logic             transaction_active,
    input  logic             direction_in,
    input  logic             setup,
    input  logic             data_strobe,
    input  logic             success,
    output logic [7:0]       data_in,
    output logic             data_in_valid,
    output logic             data_toggle,
    output logic [1:0]       handshake,
    input  logic             q_empty,
    input  logic [7:0]       q_data_out,
    output logic             q_read_success,
    output logic [CNT_W-1:0] pkt_len
);
    localparam int               AW      = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PKT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [1:0]       HS_ACK  = 2'b00;
    localparam logic [1:0]       HS_NAK  = 2'b10;

    typedef enum logic [1:0] {ST_FILL, ST_SEND, ST_WAIT} state_t;

    state_t           state;
    state_t           state_next;
    logic             reset_any;
    logic [7:0]       pkt_buf [0:(1<<AW)-1];
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] len_next;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_inc;
    logic             active_q;
    logic             strobe_q;
    logic             frozen;
    logic             toggle;
    logic             ok_seen;
    logic             start;
    logic             my_start;
    logic             strobe_rise;
    logic             send_go;
    logic             can_pop;
    logic             finish;
    logic             finish_ok;
    logic             zlp_pending;
    logic             zlp_next;

    assign reset_any   = rst | usb_rst;
    assign start       = transaction_active && !active_q;
    assign my_start    = start && (endpoint == EP_NUM) && direction_in && !setup;
    assign strobe_rise = data_strobe && !strobe_q;
    assign idx_inc     = idx + ONE;
    assign send_go     = (state == ST_FILL) && my_start && ((len != '0) || zlp_pending);
    assign finish      = (state == ST_WAIT) && !transaction_active;
    assign finish_ok   = finish && (ok_seen || success);

`ifdef USB_BULK_IN_ZLP_EN
    logic last_full;
    logic last_full_next;

    // A full packet that was ACKed owes the host a terminating zero-length packet.
    always_comb begin
        last_full_next = last_full;
        if (finish_ok) begin
            last_full_next = (len == MAX_LEN);
        end
    end

    always_ff @(posedge clk48mhz) begin
        if (reset_any) begin
            last_full <= 1'b0;
        end else begin
            last_full <= last_full_next;
        end
    end

    assign zlp_pending = last_full && (len == '0);
    assign zlp_next    = last_full_next && (len_next == '0);
`else
    assign zlp_pending = 1'b0;
    assign zlp_next    = 1'b0;
`endif

    always_ff @(posedge clk48mhz) begin
        if (reset_any) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: begin
                if (send_go) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!transaction_active || success) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!transaction_active) begin
                    state_next = ST_FILL;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    // No pop in the start cycle of an IN on an empty buffer, so the NAK decision stays consistent.
    always_comb begin
        can_pop = 1'b0;
        if (!reset_any && (state == ST_FILL) && !frozen && !q_empty && (len != MAX_LEN)
            && !(my_start && (len == '0))) begin
            can_pop = 1'b1;
        end
        q_read_success = can_pop;
    end

    always_comb begin
        len_next = len;
        if (can_pop) begin
            len_next = len + ONE;
        end
        if (finish_ok) begin
            len_next = '0;
        end
    end

    always_ff @(posedge clk48mhz) begin
        if (can_pop) begin
            pkt_buf[len[AW-1:0]] <= q_data_out;
        end
    end

    always_ff @(posedge clk48mhz) begin
        if (reset_any) begin
            active_q      <= 1'b0;
            strobe_q      <= 1'b0;
            len           <= '0;
            idx           <= '0;
            frozen        <= 1'b0;
            toggle        <= 1'b0;
            ok_seen       <= 1'b0;
            data_in       <= 8'h00;
            data_in_valid <= 1'b0;
            handshake     <= HS_NAK;
        end else begin
            active_q  <= transaction_active;
            strobe_q  <= data_strobe;
            len       <= len_next;
            handshake <= ((len_next == '0) && !zlp_next) ? HS_NAK : HS_ACK;

            if (send_go) begin
                idx           <= '0;
                frozen        <= 1'b1;
                ok_seen       <= 1'b0;
                data_in_valid <= (len != '0);
                data_in       <= (len != '0) ? pkt_buf[0] : 8'h00;
            end

            if (state == ST_SEND) begin
                ok_seen <= ok_seen | success;
                if (strobe_rise && (idx != len)) begin
                    idx <= idx_inc;
                    if (idx_inc < len) begin
                        data_in       <= pkt_buf[idx_inc[AW-1:0]];
                        data_in_valid <= 1'b1;
                    end else begin
                        data_in_valid <= 1'b0;
                    end
                end
            end

            if (state == ST_WAIT) begin
                ok_seen       <= ok_seen | success;
                data_in_valid <= 1'b0;
            end

            // An unacknowledged packet keeps buffer, length and PID for the retry.
            if (finish_ok) begin
                toggle <= ~toggle;
                frozen <= 1'b0;
            end
        end
    end

    assign data_toggle = toggle;
    assign pkt_len     = len;

endmodule
